// File: rtl/inst_mem.sv
// Instruction memory with a byte-stream program loader; combinational read port, stall while loading.
// Optional INST_MEM_RANGE_CHK_EN: out-of-range reads return NOP and set a sticky rangeErr flag.
module inst_mem #(
  parameter int DEPTH_LOG2 = 10,
  parameter int BUS_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BUS_W-1:0] instAddr,
  output logic [BUS_W-1:0] instOut,
  input  logic             ldStart,
  input  logic             ldValid,
  input  logic [7:0]       ldByte,
  output logic             ldReady,
  input  logic             ldEnd,
  output logic             ldDone,
  output logic             ldOvf,
  output logic             cpuHold,
`ifdef INST_MEM_RANGE_CHK_EN
  output logic             rangeErr,
`endif
  output logic [1:0]       o_dbg_state
);

  localparam int                    DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [BUS_W-1:0]      NOP      = BUS_W'(32'h0000_0013);
  localparam logic [DEPTH_LOG2-1:0] ADDR_ONE = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2-1:0] ADDR_MAX = '1;

  // Handshake: a load byte transfers on a rising edge where ldValid && ldReady;
  // ldReady is high exactly while in LOAD, and ldValid is ignored elsewhere.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PAD  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [DEPTH_LOG2-1:0]   r_wr_addr;
  logic [1:0]              r_byte_cnt;
  logic [23:0]             r_word;
  logic                    r_ovf;
  logic                    w_accept;
  logic [1:0]              w_cnt_post;
  logic                    w_we;
  logic [BUS_W-1:0]        w_wdata;
  logic [BUS_W-1:0]        w_rd_data;
  logic [BUS_W-1:0]        r_mem [DEPTH];

  assign w_accept   = (r_state == S_LOAD) && ldValid;
  assign w_cnt_post = w_accept ? r_byte_cnt + 2'd1 : r_byte_cnt;

  always_comb begin
    w_next_state = r_state;
    w_we         = 1'b0;
    w_wdata      = '0;
    case (r_state)
      S_IDLE: if (ldStart) w_next_state = S_LOAD;
      S_LOAD: begin
        if (w_accept && (r_byte_cnt == 2'd3)) begin
          w_we    = 1'b1;
          w_wdata = BUS_W'({ldByte, r_word});
        end
        // The same-cycle byte is already folded into w_cnt_post.
        if (ldEnd) w_next_state = (w_cnt_post == 2'd0) ? S_DONE : S_PAD;
      end
      S_PAD: begin
        w_we         = 1'b1;
        w_wdata      = BUS_W'({8'h00, r_word});
        w_next_state = S_DONE;
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_wr_addr  <= '0;
      r_byte_cnt <= 2'd0;
      r_word     <= 24'h0;
      r_ovf      <= 1'b0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: if (ldStart) begin
          r_wr_addr  <= '0;
          r_byte_cnt <= 2'd0;
          r_word     <= 24'h0;
          r_ovf      <= 1'b0;
        end
        S_LOAD: if (w_accept) begin
          r_byte_cnt <= w_cnt_post;
          // Clearing the upper bytes on byte 0 leaves a ready zero-padded partial word.
          case (r_byte_cnt)
            2'd0: r_word <= {16'h0000, ldByte};
            2'd1: r_word[15:8]  <= ldByte;
            2'd2: r_word[23:16] <= ldByte;
            default: begin
              r_word    <= 24'h0;
              r_wr_addr <= r_wr_addr + ADDR_ONE;
              if (r_wr_addr == ADDR_MAX) r_ovf <= 1'b1;
            end
          endcase
        end
        S_PAD: begin
          r_word     <= 24'h0;
          r_byte_cnt <= 2'd0;
        end
        default: ;
      endcase
    end
  end

  // Contents survive reset, so the array lives in its own unreset process.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_wr_addr] <= w_wdata;
  end

  assign w_rd_data   = r_mem[instAddr[DEPTH_LOG2-1:0]];
  assign ldReady     = (r_state == S_LOAD);
  assign ldDone      = (r_state == S_DONE);
  assign cpuHold     = (r_state != S_IDLE);
  assign ldOvf       = r_ovf;
  assign o_dbg_state = r_state;

`ifdef INST_MEM_RANGE_CHK_EN
  logic w_oor;
  logic r_range_err;

  assign w_oor = |instAddr[BUS_W-1:DEPTH_LOG2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       r_range_err <= 1'b0;
    else if (w_oor) r_range_err <= 1'b1;
  end

  assign rangeErr = r_range_err;
  assign instOut  = (cpuHold || w_oor) ? NOP : w_rd_data;
`else
  logic w_unused_addr_hi;

  assign w_unused_addr_hi = ^instAddr[BUS_W-1:DEPTH_LOG2];
  assign instOut          = cpuHold ? NOP : w_rd_data;
`endif

endmodule

// File: tb/tb_inst_mem.sv
// Directed bench for inst_mem: a default-depth instance and a 4-word instance share one load stream.
// Build with +define+INST_MEM_RANGE_CHK_EN to exercise the range-check variant.
module tb_inst_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instAddr;
  logic        ldStart, ldValid, ldEnd;
  logic [7:0]  ldByte;

  logic [31:0] instOut, s_instOut;
  logic        ldReady, s_ldReady, ldDone, s_ldDone;
  logic        ldOvf, s_ldOvf, cpuHold, s_cpuHold;
  logic [1:0]  dbg_state, s_dbg_state;
`ifdef INST_MEM_RANGE_CHK_EN
  logic        range_err, s_range_err;
`endif

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  inst_mem u_dut (
    .clk(clk), .rst(rst), .instAddr(instAddr), .instOut(instOut),
    .ldStart(ldStart), .ldValid(ldValid), .ldByte(ldByte), .ldReady(ldReady),
    .ldEnd(ldEnd), .ldDone(ldDone), .ldOvf(ldOvf), .cpuHold(cpuHold),
`ifdef INST_MEM_RANGE_CHK_EN
    .rangeErr(range_err),
`endif
    .o_dbg_state(dbg_state)
  );

  inst_mem #(.DEPTH_LOG2(2)) u_small (
    .clk(clk), .rst(rst), .instAddr(instAddr), .instOut(s_instOut),
    .ldStart(ldStart), .ldValid(ldValid), .ldByte(ldByte), .ldReady(s_ldReady),
    .ldEnd(ldEnd), .ldDone(s_ldDone), .ldOvf(s_ldOvf), .cpuHold(s_cpuHold),
`ifdef INST_MEM_RANGE_CHK_EN
    .rangeErr(s_range_err),
`endif
    .o_dbg_state(s_dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic read_check(input logic [31:0] addr, input string tag);
    logic [31:0] exp;
    instAddr = addr;
    #1;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s: observed %h expected <empty expected queue>", tag, instOut);
    end else begin
      exp = exp_q.pop_front();
      check(tag, instOut, exp);
    end
  endtask

  // drivers
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    ldValid = 1'b1;
    ldByte  = b;
    tick();
    ldValid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  task automatic ld_start;
    ldStart = 1'b1;
    tick();
    ldStart = 1'b0;
  endtask

  task automatic ld_end_pulse;
    ldEnd = 1'b1;
    tick();
    ldEnd = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int cyc;
    cyc = 0;
    while (!ldDone && cyc < 8) begin
      tick();
      cyc++;
    end
    check_bit({tag, "_done"}, ldDone, 1'b1);
    tick();
    check_bit({tag, "_done_one_cycle"}, ldDone, 1'b0);
    check_bit({tag, "_hold_released"}, cpuHold, 1'b0);
  endtask

  initial begin
    rst      = 1'b0;
    instAddr = 32'h0;
    ldStart  = 1'b0;
    ldValid  = 1'b0;
    ldEnd    = 1'b0;
    ldByte   = 8'h00;
    tick();
    tick();
    check_bit("rst_hold", cpuHold, 1'b0);
    check_bit("rst_ready", ldReady, 1'b0);
    check_bit("rst_done", ldDone, 1'b0);
    check_bit("rst_ovf", ldOvf, 1'b0);
    check("rst_state", {30'h0, dbg_state}, 32'h0);
    rst = 1'b1;
    tick();

    // two full words, no padding
    ld_start();
    check_bit("t1_hold", cpuHold, 1'b1);
    check_bit("t1_ready", ldReady, 1'b1);
    check("t1_nop_while_hold", instOut, 32'h0000_0013);
    send_word(32'h0000_0013);
    send_word(32'h0010_00B3);
    ld_end_pulse();
    check("t1_state_done", {30'h0, dbg_state}, 32'h3);
    wait_done("t1");
    exp_q.push_back(32'h0000_0013);
    exp_q.push_back(32'h0010_00B3);
    read_check(32'h0, "t1_mem0");
    read_check(32'h1, "t1_mem1");
    check_bit("t1_ovf", ldOvf, 1'b0);
`ifdef INST_MEM_RANGE_CHK_EN
    instAddr = 32'h400;
    #1;
    check("t1_range_nop", instOut, 32'h0000_0013);
    tick();
    check_bit("t1_range_err", range_err, 1'b1);
`else
    exp_q.push_back(32'h0010_00B3);
    read_check(32'h401, "t1_alias");
`endif

    // ldEnd outside LOAD is ignored
    ld_end_pulse();
    check_bit("idle_end_hold", cpuHold, 1'b0);
    check("idle_end_state", {30'h0, dbg_state}, 32'h0);

    // two bytes -> PAD path
    ld_start();
    send_byte(8'hAA);
    send_byte(8'hBB);
    ld_end_pulse();
    check("t2_state_pad", {30'h0, dbg_state}, 32'h2);
    check_bit("t2_no_done_in_pad", ldDone, 1'b0);
    wait_done("t2");
    exp_q.push_back(32'h0000_BBAA);
    exp_q.push_back(32'h0010_00B3);
    read_check(32'h0, "t2_mem0_padded");
    read_check(32'h1, "t2_mem1_kept");

    // stray ldStart mid-load, then 5th byte together with ldEnd
    ld_start();
    send_byte(8'h11);
    send_byte(8'h22);
    ld_start();
    check_bit("t3_start_ignored", ldReady, 1'b1);
    send_byte(8'h33);
    send_byte(8'h44);
    ldEnd = 1'b1;
    send_byte(8'hEE);
    ldEnd = 1'b0;
    check("t3_state_pad", {30'h0, dbg_state}, 32'h2);
    wait_done("t3");
    exp_q.push_back(32'h4433_2211);
    exp_q.push_back(32'h0000_00EE);
    read_check(32'h0, "t3_mem0");
    read_check(32'h1, "t3_mem1_padded");

    // five words: the 4-word instance wraps
    ld_start();
    for (int i = 0; i < 3; i++) send_word(32'hA000_0000 + 32'(i));
    check_bit("t4_small_ovf_early", s_ldOvf, 1'b0);
    for (int i = 3; i < 5; i++) send_word(32'hA000_0000 + 32'(i));
    ld_end_pulse();
    wait_done("t4");
    check_bit("t4_big_ovf", ldOvf, 1'b0);
    check_bit("t4_small_ovf", s_ldOvf, 1'b1);
    exp_q.push_back(32'hA000_0000);
    exp_q.push_back(32'hA000_0004);
    read_check(32'h0, "t4_big_mem0");
    read_check(32'h4, "t4_big_mem4");
    instAddr = 32'h0;
    #1;
    check("t4_small_mem0_wrapped", s_instOut, 32'hA000_0004);
    instAddr = 32'h1;
    #1;
    check("t4_small_mem1", s_instOut, 32'hA000_0001);

    // reset in the middle of the second word
    ld_start();
    check_bit("t5_small_ovf_cleared", s_ldOvf, 1'b0);
    send_word(32'hCAFE_0001);
    send_byte(8'h55);
    send_byte(8'h66);
    rst = 1'b0;
    #2;
    check_bit("t5_rst_hold", cpuHold, 1'b0);
    check_bit("t5_rst_ready", ldReady, 1'b0);
    check("t5_rst_state", {30'h0, dbg_state}, 32'h0);
    tick();
    rst = 1'b1;
    tick();
    exp_q.push_back(32'hCAFE_0001);
    exp_q.push_back(32'hA000_0001);
    read_check(32'h0, "t5_mem0_kept");
    read_check(32'h1, "t5_mem1_unchanged");
    instAddr = 32'h0;
    #1;
    check("t5_small_mem0", s_instOut, 32'hCAFE_0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
